// File: rtl/poets_system_streaming_block_id_arb_pkg.sv
// Shared types and defaults for the block-ID RAM arbiter.
//   arb_state_e : arbiter FSM states (IDLE, ISSUE, CAPTURE)
//   arb_op_e    : latched operation kind (OP_READ, OP_WRITE)
//   DEF_*       : default requester count and RAM geometry (4 requesters, 32x8 RAM)
//   wrap_inc    : modulo-n increment, used to advance the round-robin pointer
package poets_block_id_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_DATA_W  = 8;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/poets_system_streaming_block_id_arb_if.sv
// Bus bundle between the requester-side interconnect, the arbiter and the
// block-ID RAM s1 port.
//   req_*  : packed per-requester Avalon-MM signals (requester i at slice i)
//   ram_*  : single RAM port
// Modports:
//   slave  : arbiter view (consumes requests, drives the RAM)
//   master : environment view (drives requests, models the RAM)
//
// Handshake: a requester holds read/write (with address/data) asserted while
// req_waitrequest[i] is 1; the access is complete in the single cycle where
// req_waitrequest[i] is 0, and for reads req_readdata is valid in that cycle.
interface poets_system_streaming_block_id_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [NUM_REQ-1:0]        req_debugaccess;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [DATA_W-1:0]         req_readdata;

  logic [ADDR_W-1:0]         ram_address;
  logic                      ram_chipselect;
  logic                      ram_write;
  logic [DATA_W-1:0]         ram_writedata;
  logic                      ram_debugaccess;
  logic                      ram_clken;
  logic [DATA_W-1:0]         ram_readdata;

  modport slave (
    input  req_address, req_read, req_write, req_writedata, req_debugaccess,
    input  ram_readdata,
    output req_waitrequest, req_readdata,
    output ram_address, ram_chipselect, ram_write, ram_writedata,
    output ram_debugaccess, ram_clken
  );

  modport master (
    output req_address, req_read, req_write, req_writedata, req_debugaccess,
    output ram_readdata,
    input  req_waitrequest, req_readdata,
    input  ram_address, ram_chipselect, ram_write, ram_writedata,
    input  ram_debugaccess, ram_clken
  );
endinterface

// File: rtl/poets_system_streaming_block_id_arb_rr_pick.sv
// Combinational round-robin selector.
//   active_i      : one bit per requester with a pending access
//   rr_ptr_i      : index with highest priority this round
//   grant_idx_o   : first active index at or after rr_ptr_i (modulo NUM_REQ)
//   grant_valid_o : any requester active
module poets_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] active_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_valid_o
);

  always_comb begin
    int idx;
    idx           = 0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      // First hit wins; later hits in the scan are lower priority.
      if (!grant_valid_o && active_i[IDX_W'(idx)]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/poets_system_streaming_block_id_arb.sv
// Round-robin arbiter sharing the single-port block-ID RAM between NUM_REQ
// Avalon-MM requesters. One access at a time: IDLE picks a requester,
// ISSUE presents the latched address to the RAM, CAPTURE returns read data
// (the RAM registers its address, so data appears one cycle after ISSUE).
// Writes finish in ISSUE.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   freeze     : inhibits new grants while high (in-flight access completes)
//   bus        : requester and RAM signals (slave modport)
//   state_o    : current FSM state, for observation
//
// Build option POETS_BLOCK_ID_ARB_WRITE_EN: when defined, write requests are
// forwarded to the RAM (ram_write plus the requester's debugaccess); when
// undefined the RAM is read-only and writes complete with data discarded.
module poets_system_streaming_block_id_arb
  import poets_block_id_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       freeze,
  poets_system_streaming_block_id_arb_if.slave bus,
  output arb_state_e state_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q;
  arb_op_e            op_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   rr_next_d;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [NUM_REQ-1:0] active;
  logic [ADDR_W-1:0]  ram_address_q;
  logic [DATA_W-1:0]  ram_writedata_q;
  logic               ram_chipselect_q;
  logic [NUM_REQ-1:0] waitrequest_d;
  logic [DATA_W-1:0]  readdata_d;
`ifdef POETS_BLOCK_ID_ARB_WRITE_EN
  logic               ram_write_q;
  logic               ram_debugaccess_q;
`endif

  assign active = bus.req_read | bus.req_write;

  poets_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .active_i      (active),
    .rr_ptr_i      (rr_ptr_q),
    .grant_idx_o   (pick_idx),
    .grant_valid_o (pick_valid)
  );

  // Priority moves to the requester just after the one being completed.
  assign rr_next_d = IDX_W'(wrap_inc(32'(grant_q), NUM_REQ));

  // RAM-side outputs are registered: they are loaded on the IDLE->ISSUE edge
  // so they are valid exactly during ISSUE, and cleared on leaving ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      op_q              <= OP_READ;
      rr_ptr_q          <= '0;
      grant_q           <= '0;
      ram_address_q     <= '0;
      ram_writedata_q   <= '0;
      ram_chipselect_q  <= 1'b0;
`ifdef POETS_BLOCK_ID_ARB_WRITE_EN
      ram_write_q       <= 1'b0;
      ram_debugaccess_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!freeze && pick_valid) begin
            state_q          <= ISSUE;
            grant_q          <= pick_idx;
            // Read+write together is treated as a write.
            op_q             <= bus.req_write[pick_idx] ? OP_WRITE : OP_READ;
            ram_address_q    <= bus.req_address[pick_idx*ADDR_W +: ADDR_W];
            ram_writedata_q  <= bus.req_writedata[pick_idx*DATA_W +: DATA_W];
            ram_chipselect_q <= 1'b1;
`ifdef POETS_BLOCK_ID_ARB_WRITE_EN
            ram_write_q       <= bus.req_write[pick_idx];
            ram_debugaccess_q <= bus.req_debugaccess[pick_idx];
`endif
          end
        end
        ISSUE: begin
          ram_chipselect_q <= 1'b0;
`ifdef POETS_BLOCK_ID_ARB_WRITE_EN
          ram_write_q       <= 1'b0;
          ram_debugaccess_q <= 1'b0;
`endif
          if (op_q == OP_WRITE) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_next_d;
          end else begin
            state_q  <= CAPTURE;
          end
        end
        CAPTURE: begin
          state_q  <= IDLE;
          rr_ptr_q <= rr_next_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Completion is the write's ISSUE cycle or the read's CAPTURE cycle.
  always_comb begin
    waitrequest_d = '1;
    readdata_d    = '0;
    if ((state_q == ISSUE && op_q == OP_WRITE) || state_q == CAPTURE)
      waitrequest_d[grant_q] = 1'b0;
    if (state_q == CAPTURE)
      readdata_d = bus.ram_readdata;
  end

  assign bus.req_waitrequest = waitrequest_d;
  assign bus.req_readdata    = readdata_d;
  assign bus.ram_address     = ram_address_q;
  assign bus.ram_chipselect  = ram_chipselect_q;
  assign bus.ram_writedata   = ram_writedata_q;
  assign bus.ram_clken       = 1'b1;
`ifdef POETS_BLOCK_ID_ARB_WRITE_EN
  assign bus.ram_write       = ram_write_q;
  assign bus.ram_debugaccess = ram_debugaccess_q;
`else
  assign bus.ram_write       = 1'b0;
  assign bus.ram_debugaccess = 1'b0;
`endif
  assign state_o = state_q;

endmodule

// File: tb/tb_poets_system_streaming_block_id_arb.sv
// Directed testbench for poets_system_streaming_block_id_arb with a
// behavioural 32x8 RAM (registered address, unregistered read data).
// Inputs change and outputs are sampled 1 time unit after the falling edge.
module tb_poets_system_streaming_block_id_arb;
  import poets_block_id_arb_pkg::*;

`ifdef POETS_BLOCK_ID_ARB_WRITE_EN
  localparam logic WE_EN = 1'b1;
`else
  localparam logic WE_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       freeze;
  arb_state_e state;

  int n_checks = 0;
  int n_fail   = 0;

  poets_system_streaming_block_id_arb_if #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(8)) bus ();

  poets_system_streaming_block_id_arb #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .freeze  (freeze),
    .bus     (bus.slave),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  // ---------------- RAM model ----------------
  // Contents: word i = 0x10+i, except word 3 = 0x2A and word 7 = 0x33.
  logic       mem_init;
  logic [7:0] mem [32];
  logic [4:0] ram_addr_q;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(8'h10 + i);
      mem[3]     <= 8'h2A;
      mem[7]     <= 8'h33;
      ram_addr_q <= 5'd0;
    end else if (bus.ram_clken && bus.ram_chipselect) begin
      ram_addr_q <= bus.ram_address;
      if (bus.ram_write && bus.ram_debugaccess) mem[bus.ram_address] <= bus.ram_writedata;
    end
  end

  assign bus.ram_readdata = mem[ram_addr_q];

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr,
                         input logic [4:0] a, input logic [7:0] d, input logic dbg);
    bus.req_read[i]            = rd;
    bus.req_write[i]           = wr;
    bus.req_address[i*5 +: 5]  = a;
    bus.req_writedata[i*8 +: 8] = d;
    bus.req_debugaccess[i]     = dbg;
  endtask

  // Issues reads from every requester in mask (requester i reads rd_addr[i]),
  // starting in the current cycle (cycle 1), and records completion order,
  // cycle and data. Each requester drops its request when it completes.
  logic [4:0] rd_addr [4];
  int         done_order [$];
  int         done_cyc [4];
  logic [7:0] done_data [4];

  task automatic run_reads(input logic [3:0] mask);
    logic [3:0] pending;
    done_order.delete();
    for (int i = 0; i < 4; i++) begin
      done_cyc[i]  = -1;
      done_data[i] = 8'hXX;
      if (mask[i]) set_req(i, 1'b1, 1'b0, rd_addr[i], 8'h00, 1'b0);
    end
    pending = mask;
    for (int c = 1; c <= 30 && pending != 4'b0; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_waitrequest[i] === 1'b0) begin
          done_order.push_back(i);
          done_cyc[i]  = c;
          done_data[i] = bus.req_readdata;
          pending[i]   = 1'b0;
          set_req(i, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
        end
      end
      cyc();
    end
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; mem_init = 1'b1; freeze = 1'b0;
    bus.req_read = '0; bus.req_write = '0; bus.req_address = '0;
    bus.req_writedata = '0; bus.req_debugaccess = '0;
    cyc(); cyc(); cyc();
    n_checks++; if (bus.req_waitrequest !== 4'hF) begin n_fail++; $display("FAIL reset_wait: got %h want f", bus.req_waitrequest); end
    n_checks++; if (bus.ram_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b want 0", bus.ram_chipselect); end
    n_checks++; if (bus.ram_write !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.ram_write); end
    n_checks++; if (bus.ram_address !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.ram_address); end
    n_checks++; if (bus.ram_writedata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus.ram_writedata); end
    n_checks++; if (bus.ram_debugaccess !== 1'b0) begin n_fail++; $display("FAIL reset_dbg: got %b want 0", bus.ram_debugaccess); end
    n_checks++; if (bus.req_readdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.req_readdata); end
    n_checks++; if (bus.ram_clken !== 1'b1) begin n_fail++; $display("FAIL reset_clken: got %b want 1", bus.ram_clken); end
    n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, IDLE); end
    reset = 1'b0; mem_init = 1'b0;
    cyc();
    n_checks++; if (state !== IDLE) begin n_fail++; $display("FAIL post_reset_state: got %0d want %0d", state, IDLE); end
  endtask

  task automatic test_round_robin();
    int exp_order [4];
    exp_order = '{0, 1, 2, 3};
    for (int i = 0; i < 4; i++) rd_addr[i] = 5'(8 + i);
    run_reads(4'b1111);
    n_checks++; if (done_order.size() !== 4) begin n_fail++; $display("FAIL rr_count: got %0d want 4", done_order.size()); end
    for (int k = 0; k < 4 && k < done_order.size(); k++) begin
      n_checks++; if (done_order[k] !== exp_order[k]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, done_order[k], exp_order[k]); end
    end
    // Read latency 3, plus one IDLE cycle between consecutive grants.
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (done_cyc[i] !== 3 * (i + 1)) begin n_fail++; $display("FAIL rr_cycle[%0d]: got %0d want %0d", i, done_cyc[i], 3 * (i + 1)); end
      n_checks++; if (done_data[i] !== 8'(8'h18 + i)) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", i, done_data[i], 8'(8'h18 + i)); end
    end
    // Pointer wrapped to 0: requester 1 then 3.
    run_reads(4'b1010);
    n_checks++; if (done_order.size() !== 2) begin n_fail++; $display("FAIL rr2_count: got %0d want 2", done_order.size()); end
    if (done_order.size() == 2) begin
      n_checks++; if (done_order[0] !== 1 || done_order[1] !== 3) begin n_fail++; $display("FAIL rr2_order: got %0d,%0d want 1,3", done_order[0], done_order[1]); end
    end
    n_checks++; if (done_cyc[1] !== 3 || done_cyc[3] !== 6) begin n_fail++; $display("FAIL rr2_cycles: got %0d,%0d want 3,6", done_cyc[1], done_cyc[3]); end
    n_checks++; if (done_data[3] !== 8'h1B) begin n_fail++; $display("FAIL rr2_data3: got %h want 1b", done_data[3]); end
  endtask

  task automatic test_single_read();
    set_req(0, 1'b1, 1'b0, 5'd3, 8'h00, 1'b0);
    n_checks++; if (bus.req_waitrequest !== 4'hF) begin n_fail++; $display("FAIL rd_c1_wait: got %h want f", bus.req_waitrequest); end
    cyc();
    n_checks++; if (state !== ISSUE) begin n_fail++; $display("FAIL rd_c2_state: got %0d want %0d", state, ISSUE); end
    n_checks++; if (bus.ram_chipselect !== 1'b1 || bus.ram_address !== 5'd3) begin n_fail++; $display("FAIL rd_c2_ram: got cs=%b addr=%h want cs=1 addr=03", bus.ram_chipselect, bus.ram_address); end
    n_checks++; if (bus.req_waitrequest !== 4'hF) begin n_fail++; $display("FAIL rd_c2_wait: got %h want f", bus.req_waitrequest); end
    n_checks++; if (bus.ram_write !== 1'b0) begin n_fail++; $display("FAIL rd_c2_we: got %b want 0", bus.ram_write); end
    // Changing the address mid-access must not affect the result.
    bus.req_address[4:0] = 5'd9;
    cyc();
    n_checks++; if (bus.req_waitrequest !== 4'hE) begin n_fail++; $display("FAIL rd_c3_wait: got %h want e", bus.req_waitrequest); end
    n_checks++; if (bus.req_readdata !== 8'h2A) begin n_fail++; $display("FAIL rd_c3_data: got %h want 2a", bus.req_readdata); end
    n_checks++; if (bus.ram_chipselect !== 1'b0 || bus.ram_write !== 1'b0) begin n_fail++; $display("FAIL rd_c3_ram: got cs=%b we=%b want 0,0", bus.ram_chipselect, bus.ram_write); end
    set_req(0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    cyc();
    n_checks++; if (bus.req_waitrequest !== 4'hF || state !== IDLE) begin n_fail++; $display("FAIL rd_c4_idle: got wait=%h state=%0d want f,%0d", bus.req_waitrequest, state, IDLE); end
    n_checks++; if (bus.req_readdata !== 8'h00) begin n_fail++; $display("FAIL rd_c4_rdata: got %h want 0", bus.req_readdata); end
  endtask

  task automatic test_write(input logic rd_too, input logic dbg, input logic [7:0] d,
                            input logic [7:0] exp_rb);
    set_req(2, rd_too, 1'b1, 5'd7, d, dbg);
    n_checks++; if (bus.req_waitrequest !== 4'hF) begin n_fail++; $display("FAIL wr_c1_wait: got %h want f", bus.req_waitrequest); end
    cyc();
    n_checks++; if (bus.req_waitrequest !== 4'hB) begin n_fail++; $display("FAIL wr_c2_wait: got %h want b", bus.req_waitrequest); end
    n_checks++; if (bus.ram_chipselect !== 1'b1 || bus.ram_address !== 5'd7 || bus.ram_writedata !== d) begin n_fail++; $display("FAIL wr_c2_ram: got cs=%b addr=%h wd=%h want 1,07,%h", bus.ram_chipselect, bus.ram_address, bus.ram_writedata, d); end
    n_checks++; if (bus.ram_write !== WE_EN) begin n_fail++; $display("FAIL wr_c2_we: got %b want %b", bus.ram_write, WE_EN); end
    n_checks++; if (bus.ram_debugaccess !== (WE_EN & dbg)) begin n_fail++; $display("FAIL wr_c2_dbg: got %b want %b", bus.ram_debugaccess, WE_EN & dbg); end
    set_req(2, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    cyc();
    n_checks++; if (bus.ram_write !== 1'b0 || bus.ram_chipselect !== 1'b0 || bus.req_waitrequest !== 4'hF) begin n_fail++; $display("FAIL wr_c3_idle: got we=%b cs=%b wait=%h want 0,0,f", bus.ram_write, bus.ram_chipselect, bus.req_waitrequest); end
    rd_addr[0] = 5'd7;
    run_reads(4'b0001);
    n_checks++; if (done_cyc[0] !== 3 || done_data[0] !== exp_rb) begin n_fail++; $display("FAIL wr_readback: got cyc=%0d data=%h want 3,%h", done_cyc[0], done_data[0], exp_rb); end
  endtask

  task automatic test_reset_mid_read();
    set_req(0, 1'b1, 1'b0, 5'd3, 8'h00, 1'b0);
    cyc();
    n_checks++; if (state !== ISSUE || bus.ram_chipselect !== 1'b1) begin n_fail++; $display("FAIL rst_mid_issue: got state=%0d cs=%b want %0d,1", state, bus.ram_chipselect, ISSUE); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.req_waitrequest !== 4'hF || bus.ram_chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_mid_abort: got wait=%h cs=%b want f,0", bus.req_waitrequest, bus.ram_chipselect); end
    n_checks++; if (state !== IDLE || bus.ram_address !== 5'd0) begin n_fail++; $display("FAIL rst_mid_state: got state=%0d addr=%h want %0d,00", state, bus.ram_address, IDLE); end
    set_req(0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    cyc(); cyc();
    n_checks++; if (bus.ram_chipselect !== 1'b0 || bus.req_waitrequest !== 4'hF) begin n_fail++; $display("FAIL rst_mid_hold: got cs=%b wait=%h want 0,f", bus.ram_chipselect, bus.req_waitrequest); end
    reset = 1'b0;
    cyc();
    n_checks++; if (state !== IDLE || bus.req_waitrequest !== 4'hF) begin n_fail++; $display("FAIL rst_mid_release: got state=%0d wait=%h want %0d,f", state, bus.req_waitrequest, IDLE); end
  endtask

  task automatic test_freeze();
    // Pointer is 0 after the reset: requester 1 is granted first.
    set_req(1, 1'b1, 1'b0, 5'd4, 8'h00, 1'b0);
    set_req(2, 1'b1, 1'b0, 5'd5, 8'h00, 1'b0);
    cyc();
    n_checks++; if (state !== ISSUE || bus.ram_address !== 5'd4) begin n_fail++; $display("FAIL frz_issue: got state=%0d addr=%h want %0d,04", state, bus.ram_address, ISSUE); end
    freeze = 1'b1;
    cyc();
    n_checks++; if (bus.req_waitrequest !== 4'hD || bus.req_readdata !== 8'h14) begin n_fail++; $display("FAIL frz_r1_done: got wait=%h data=%h want d,14", bus.req_waitrequest, bus.req_readdata); end
    set_req(1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_checks++; if (state !== IDLE || bus.req_waitrequest !== 4'hF || bus.ram_chipselect !== 1'b0) begin n_fail++; $display("FAIL frz_hold[%0d]: got state=%0d wait=%h cs=%b want %0d,f,0", k, state, bus.req_waitrequest, bus.ram_chipselect, IDLE); end
    end
    freeze = 1'b0;
    cyc();
    n_checks++; if (state !== ISSUE || bus.req_waitrequest !== 4'hF) begin n_fail++; $display("FAIL frz_r2_issue: got state=%0d wait=%h want %0d,f", state, bus.req_waitrequest, ISSUE); end
    cyc();
    n_checks++; if (bus.req_waitrequest !== 4'hB || bus.req_readdata !== 8'h15) begin n_fail++; $display("FAIL frz_r2_done: got wait=%h data=%h want b,15", bus.req_waitrequest, bus.req_readdata); end
    set_req(2, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
    cyc();
    n_checks++; if (state !== IDLE || bus.req_waitrequest !== 4'hF) begin n_fail++; $display("FAIL frz_end: got state=%0d wait=%h want %0d,f", state, bus.req_waitrequest, IDLE); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    // debugaccess=1 commits when writes are enabled; debugaccess=0 (with read
    // also asserted, still a 2-cycle write) must leave the word unchanged.
    test_write(1'b0, 1'b1, 8'h55, WE_EN ? 8'h55 : 8'h33);
    test_write(1'b1, 1'b0, 8'hAA, WE_EN ? 8'h55 : 8'h33);
    test_reset_mid_read();
    test_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
